// File: rtl/ysyx_22050243_pipe_pkg.sv
// ysyx_22050243_pipe_pkg: shared slice state encoding and perf counter width
package ysyx_22050243_pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} slice_state_t;
  localparam int PERF_CNT_W = 32;
endpackage

// File: rtl/ysyx_22050243_perf_cnt.sv
// ysyx_22050243_perf_cnt: enable-driven wrapping event counter
module ysyx_22050243_perf_cnt
  import ysyx_22050243_pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic [PERF_CNT_W-1:0] cnt
);
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (en) cnt <= cnt + PERF_CNT_W'(1);
endmodule

// File: rtl/ysyx_22050243_skid_slice.sv
// ysyx_22050243_skid_slice: registered valid/ready slice with 2-entry skid buffer, flush and stall
// Defining YSYX_22050243_SLICE_PERF_EN adds transfer and back-pressure counters.
module ysyx_22050243_skid_slice
  import ysyx_22050243_pipe_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  stall,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef YSYX_22050243_SLICE_PERF_EN
  ,output logic [PERF_CNT_W-1:0] perf_xfer_cnt,
  output logic [PERF_CNT_W-1:0] perf_bp_cnt
`endif
);
  slice_state_t state, state_n;
  logic [DATA_WIDTH-1:0] main_q, main_n, skid_q, skid_n;
  logic s_fire, m_fire;
  // ready/valid come straight from the state register, so m_ready never reaches s_ready
  assign m_valid = state != EMPTY;
  assign s_ready = state != SKID;
  assign m_data  = main_q;
  assign s_fire  = s_valid & s_ready & ~stall;
  assign m_fire  = m_valid & m_ready & ~stall;
  always_ff @(posedge clk)
    if (rst) begin
      state  <= EMPTY;
      main_q <= RST_VAL;
      skid_q <= RST_VAL;
    end else begin
      state  <= state_n;
      main_q <= main_n;
      skid_q <= skid_n;
    end
  always_comb begin
    state_n = state;
    main_n  = main_q;
    skid_n  = skid_q;
    if (flush) begin
      state_n = EMPTY;
      main_n  = RST_VAL;
      skid_n  = RST_VAL;
    end else
      case (state)
        EMPTY: if (s_fire) begin
          state_n = FULL;
          main_n  = s_data;
        end
        FULL: if (s_fire && !m_fire) begin
          state_n = SKID;
          skid_n  = s_data;
        end else if (m_fire && !s_fire) begin
          state_n = EMPTY;
          main_n  = RST_VAL;
        end else if (s_fire) main_n = s_data;
        SKID: if (m_fire) begin
          state_n = FULL;
          main_n  = skid_q;
          skid_n  = RST_VAL;
        end
        default: state_n = EMPTY;
      endcase
  end
`ifdef YSYX_22050243_SLICE_PERF_EN
  ysyx_22050243_perf_cnt u_xfer (.clk(clk), .rst(rst), .en(m_fire), .cnt(perf_xfer_cnt));
  ysyx_22050243_perf_cnt u_bp (.clk(clk), .rst(rst), .en(m_valid & ~m_ready & ~stall), .cnt(perf_bp_cnt));
`endif
endmodule

// File: tb/tb_ysyx_22050243_skid_slice.sv
// tb_ysyx_22050243_skid_slice: vector table plus queue scoreboard for the skid slice
module tb_ysyx_22050243_skid_slice;
  logic clk = 0, rst = 0, flush = 0, stall = 0, s_valid = 0, m_ready = 0;
  logic s_ready, m_valid;
  logic [31:0] s_data = '0, m_data;
`ifdef YSYX_22050243_SLICE_PERF_EN
  logic [31:0] perf_xfer_cnt, perf_bp_cnt;
`endif
  int tests = 0, fails = 0, xfers = 0;
  logic [31:0] q[$];
  typedef struct {
    logic sv; logic [31:0] sd; logic mr, st, fl;
    logic mv, sr; logic [31:0] md;
  } vec_t;
  vec_t tbl[23];

  ysyx_22050243_skid_slice #(.DATA_WIDTH(32), .RST_VAL(32'h0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef YSYX_22050243_SLICE_PERF_EN
    , .perf_xfer_cnt(perf_xfer_cnt), .perf_bp_cnt(perf_bp_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [31:0] sd, input logic mr, input logic st, input logic fl);
    s_valid = sv; s_data = sd; m_ready = mr; stall = st; flush = fl;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst = 1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 0;
    q.delete();
  endtask

  // called at a negedge; checks outputs against the queue model, then runs one cycle
  task automatic step(input logic sv, input logic [31:0] sd, input logic mr, input logic st, input logic fl);
    logic sf, mf;
    chk("sb_m_valid", m_valid, q.size() > 0);
    chk("sb_s_ready", s_ready, q.size() < 2);
    chk("sb_m_data", m_data, q.size() > 0 ? q[0] : 32'h0);
    drive(sv, sd, mr, st, fl);
    sf = sv && q.size() < 2 && !st && !fl;
    mf = q.size() > 0 && mr && !st && !fl;
    if (m_valid && mr && !st && !fl) xfers++;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (mf) void'(q.pop_front());
      if (sf) q.push_back(sd);
    end
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{1, 32'hA, 0, 0, 0, 1, 1, 32'hA};
    tbl[1]  = '{1, 32'hB, 0, 0, 0, 1, 0, 32'hA};
    tbl[2]  = '{1, 32'hC, 0, 0, 0, 1, 0, 32'hA};
    tbl[3]  = '{0, 32'h0, 1, 0, 0, 1, 1, 32'hB};
    tbl[4]  = '{0, 32'h0, 1, 0, 0, 0, 1, 32'h0};
    tbl[5]  = '{1, 32'hA, 0, 0, 0, 1, 1, 32'hA};
    tbl[6]  = '{1, 32'hB, 0, 0, 0, 1, 0, 32'hA};
    tbl[7]  = '{1, 32'hC, 1, 0, 1, 0, 1, 32'h0};
    tbl[8]  = '{0, 32'h0, 1, 0, 0, 0, 1, 32'h0};
    tbl[9]  = '{1, 32'h5, 1, 0, 0, 1, 1, 32'h5};
    tbl[10] = '{1, 32'h6, 1, 1, 0, 1, 1, 32'h5};
    tbl[11] = '{1, 32'h6, 1, 1, 0, 1, 1, 32'h5};
    tbl[12] = '{1, 32'h6, 1, 1, 0, 1, 1, 32'h5};
    tbl[13] = '{1, 32'h6, 1, 0, 0, 1, 1, 32'h6};
    tbl[14] = '{1, 32'h7, 1, 0, 0, 1, 1, 32'h7};
    tbl[15] = '{0, 32'h0, 1, 0, 0, 0, 1, 32'h0};
    tbl[16] = '{1, 32'h8, 0, 0, 0, 1, 1, 32'h8};
    tbl[17] = '{1, 32'h9, 0, 0, 0, 1, 0, 32'h8};
    tbl[18] = '{0, 32'h0, 1, 1, 0, 1, 0, 32'h8};
    tbl[19] = '{0, 32'h0, 1, 0, 0, 1, 1, 32'h9};
    tbl[20] = '{0, 32'h0, 1, 0, 0, 0, 1, 32'h0};
    tbl[21] = '{1, 32'h3, 0, 0, 0, 1, 1, 32'h3};
    tbl[22] = '{0, 32'h0, 0, 1, 1, 0, 1, 32'h0};

    do_reset();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_data", m_data, 32'h0);
    step(0, 0, 0, 0, 0);

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].sv, tbl[i].sd, tbl[i].mr, tbl[i].st, tbl[i].fl);
      @(negedge clk);
      chk($sformatf("vec%0d_m_valid", i), m_valid, tbl[i].mv);
      chk($sformatf("vec%0d_s_ready", i), s_ready, tbl[i].sr);
      chk($sformatf("vec%0d_m_data", i), m_data, tbl[i].md);
    end

    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    q.delete();
    xfers = 0;
    for (int k = 1; k <= 8; k++) step(1, k, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("stream_beats", xfers, 8);

    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
    for (int n = 0; n < 3; n++) step(0, 0, 1, 0, 0);

`ifdef YSYX_22050243_SLICE_PERF_EN
    do_reset();
    chk("perf_rst_xfer", perf_xfer_cnt, 0);
    chk("perf_rst_bp", perf_bp_cnt, 0);
    for (int k = 1; k <= 9; k++) step(1, k, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 32'h77, 0, 0, 0);
    for (int n = 0; n < 4; n++) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("perf_xfer", perf_xfer_cnt, 10);
    chk("perf_bp", perf_bp_cnt, 4);
    step(0, 0, 0, 0, 1);
    chk("perf_flush_xfer", perf_xfer_cnt, 10);
    chk("perf_flush_bp", perf_bp_cnt, 4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ysyx_22050243_skid_slice.md
# ysyx_22050243_skid_slice

Parametrised pipeline register slice with valid/ready handshake, 2-entry skid buffer, synchronous flush and stall. Sits between any two pipeline stages of the core (IF/ID, ID/EX, EX/MEM, MEM/WB) and replaces plain stall/flush register slices. Back-pressure is fully registered, so no combinational path runs from downstream ready to upstream ready. Full throughput is sustained.

## Interface
- `DATA_WIDTH`, default 32: payload width in bits, minimum 1.
- `RST_VAL`, default 0: value driven on `m_data` when the slice is empty, after reset and after flush.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  discards all held entries. Synchronous.
- `stall`  in  1  freezes the slice: no accept, no emit, contents held.
- `s_valid`  in  1  upstream payload valid.
- `s_ready`  out  1  slice can accept; registered.
- `s_data`  in  DATA_WIDTH  upstream payload.
- `m_valid`  out  1  downstream payload valid; registered.
- `m_ready`  in  1  downstream accepts.
- `m_data`  out  DATA_WIDTH  downstream payload; registered.

## Operation
- Firing conditions:
  - s_fire = s_valid & s_ready & ~stall.
  - m_fire = m_valid & m_ready & ~stall.
- Storage: main register (drives `m_data`) plus one skid register.
- States: EMPTY (0 entries), FULL (main only), SKID (main + skid).
- Outputs per state:
  - `m_valid` = (state != EMPTY).
  - `s_ready` = (state != SKID).
- Transitions:
  - EMPTY: s_fire -> FULL, main <= s_data.
  - FULL: s_fire & ~m_fire -> SKID, skid <= s_data.
  - FULL: ~s_fire & m_fire -> EMPTY, main <= RST_VAL.
  - FULL: s_fire & m_fire -> FULL, main <= s_data.
  - SKID: m_fire -> FULL, main <= skid, skid <= RST_VAL. s_fire cannot occur in SKID.
- Flush:
  - Next state is EMPTY; main and skid load RST_VAL.
  - A handshake that coincides with flush is discarded, on both ports.
- Stall: state and registers hold. `s_ready` and `m_valid` still show their current values, but no transfer occurs.
- Priority: rst > flush > stall > handshake.
- Ordering: strict FIFO. The skid entry is never emitted before the main entry.

## Timing
- Reset values: `m_valid`=0, `s_ready`=1, `m_data`=RST_VAL, state EMPTY.
- Latency: s_fire in cycle N -> `m_valid`=1 with that data in cycle N+1.
- Throughput: 1 transfer/cycle while `m_ready`=1.
- Back-pressure: `s_ready` falls one cycle after the first cycle with `m_ready`=0 and a new s_fire. The skid register absorbs that in-flight beat.
- Flush in cycle N: `m_valid`=0 and `s_ready`=1 in N+1.
- Reset mid-transfer has the same effect as flush and also clears the perf counters.
- `m_data` is stable while `m_valid`=1 and no m_fire occurs.

## Configuration
- Macro: `YSYX_22050243_SLICE_PERF_EN`.
- Defined:
  - Adds output `perf_xfer_cnt` [31:0]: counts m_fire.
  - Adds output `perf_bp_cnt` [31:0]: counts cycles with m_valid & ~m_ready & ~stall.
  - Both counters wrap modulo 2^32, reset to 0 on rst, and are unaffected by flush.
- Undefined: the ports and the counter logic are absent. Handshake behaviour is identical in both builds.

## Structure
- Package `ysyx_22050243_pipe_pkg` holds:
  - the state typedef (`slice_state_t`: EMPTY, FULL, SKID, 2 bits);
  - `PERF_CNT_W` = 32.
- Sub-module `ysyx_22050243_perf_cnt` (enable-driven wrapping counter, width `PERF_CNT_W`) is instantiated twice, only under the macro.

## Test plan
- Reset then idle, DATA_WIDTH=32, RST_VAL=0 -> `m_valid`=0, `s_ready`=1, `m_data`=0x0.
- Stream 0x1..0x8 with `m_ready`=1 -> 8 beats out, one per cycle, 1-cycle latency, order 1..8.
- Push 0xA, 0xB with `m_ready`=0 -> state SKID, `s_ready`=0. Raise `m_ready` -> 0xA, then 0xB, on consecutive cycles; `s_ready`=1 the cycle after 0xA leaves.
- SKID state plus flush, with `s_valid`=1 -> next cycle `m_valid`=0, `s_ready`=1, `m_data`=RST_VAL; 0xA/0xB never appear.
- `stall`=1 for 3 cycles with `s_valid`=`m_ready`=1 -> no transfers, `m_data` unchanged. Release -> transfers resume, no duplicate and no loss.
- Perf build: 10 transfers plus 4 back-pressure cycles -> `perf_xfer_cnt`=10, `perf_bp_cnt`=4. Flush -> values kept.
